mha_out_collector: RTL and testbench
====================================

# mha_out_collector

Downstream stage of the multi-head-attention matmul path. Captures each accumulated result block from the systolic wrapper on the rising edge of `acc_done_wrap` and buffers it in a small FIFO. Drains the buffer into the output BRAM write port with row-major block addressing under backpressure. Signals completion once a full `ROW_BLOCKS x COL_BLOCKS` result matrix has been written.

## Interface
- `WIDTH_OUT`, 64, bits in one accumulated result block
- `ROW_BLOCKS`, 4, block rows of matrix C
- `COL_BLOCKS`, 4, block columns of matrix C
- `FIFO_DEPTH`, 4, capture FIFO entries; power of two, ≥2
- `ADDR_WIDTH`, 4, output address width; must be ≥ clog2(`ROW_BLOCKS*COL_BLOCKS`)

Ports:
- `clk`  in  1  single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse arming collection of a new matrix
- `acc_done_wrap`  in  1  level from the systolic wrapper; a rising edge means a result is present on `acc_data`
- `acc_data`  in  `WIDTH_OUT`  result block, sampled in the edge cycle
- `out_ready`  in  1  output BRAM/consumer accepts a write this cycle
- `out_we`  out  1  one-cycle write strobe per block
- `out_addr`  out  `ADDR_WIDTH`  equals `row*COL_BLOCKS + col`
- `out_data`  out  `WIDTH_OUT`  block being written
- `busy`  out  1  high in COLLECT or DRAIN
- `done`  out  1  full matrix written; held until the next accepted `start`
- `overflow`  out  1  sticky: a capture was dropped because the FIFO was full

## Operation
- **FSM states:** IDLE, COLLECT, DRAIN, DONE. Reset state is IDLE.
- **IDLE / DONE:**
  - `start` causes a transition to COLLECT.
  - On that transition, clear the capture count, write count, row/col counters and `overflow`, and flush the FIFO.
  - Edges on `acc_done_wrap` are ignored in these states and never set `overflow`.
- **COLLECT / DRAIN:** `start` is ignored.
- **Edge detect:** `acc_done_wrap_d` is a register with reset value 0. `edge = acc_done_wrap & ~acc_done_wrap_d`. A level held high produces exactly one capture.
- **Capture (COLLECT only):**
  - On `edge`, push `acc_data` and increment the capture count.
  - If the FIFO is full and no pop occurs in the same cycle, drop the data, set `overflow`, and still increment the capture count.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- **COLLECT → DRAIN:** when the capture count reaches `ROW_BLOCKS*COL_BLOCKS`. Edges in DRAIN are ignored.
- **Pop:** occurs when the FIFO is non-empty, `out_ready`=1, and the state is COLLECT or DRAIN. The pop registers `out_we`=1, `out_data`=head, `out_addr`=`row*COL_BLOCKS+col`.
- **Counter advance:** `col` increments on each pop. When `col` = `COL_BLOCKS-1` it wraps to 0 and `row` increments. Write count increments on each pop.
- **Dropped captures** consume no address. Later blocks shift down and the matrix never completes. `overflow` flags this as a fatal upstream error.
- **DRAIN → DONE:** when the write count equals `ROW_BLOCKS*COL_BLOCKS` and the FIFO is empty.
- **Arithmetic:** address product computed at `ADDR_WIDTH`, unsigned, no saturation. Counters are sized to clog2 of their range.

## Timing
- **Reset (async):** all outputs 0, `out_addr`/`out_data` 0, FSM in IDLE, FIFO empty, all counters 0, `acc_done_wrap_d` 0.
  - Takes effect immediately, including mid-COLLECT/DRAIN.
  - After release, a new `start` is required.
- **`start`** sampled in cycle t: `busy`=1 in cycle t+1.
- **Capture-to-write latency:** `edge` in cycle t pushes at the end of t. With `out_ready`=1 in t+1, `out_we`=1 in t+2.
- **`out_we` pulse:** always exactly one cycle. No write in any cycle where `out_ready` was 0 in the decision cycle.
- **Throughput:** one write per cycle while the FIFO is non-empty and `out_ready`=1.
- **`done`:** high in the cycle after the final `out_we` pulse. `busy` falls in the same cycle.
- **`overflow`:** high in the cycle after the dropping edge.

## Test plan
- **Reset:** assert `rst` asynchronously mid-DRAIN → all outputs 0 without a clock edge. After release, `start` plus 16 edges produce addresses 0..15.
- **Basic matrix** (`ROW_BLOCKS`=`COL_BLOCKS`=2): `start`, `out_ready`=1, edges carrying 0xA,0xB,0xC,0xD spaced 5 cycles apart → `out_we` at edge+2 with addr/data 0/0xA, 1/0xB, 2/0xC, 3/0xD. `done`=1 one cycle after the 4th write and held.
- **Backpressure** (defaults): `out_ready`=0, 4 edges fill the FIFO. A 5th edge → `overflow`=1, data dropped. `out_ready`=1 → writes addr 0..3 on consecutive cycles with the first four data values.
- **Full FIFO with simultaneous pop:** FIFO full, `out_ready`=1, edge in the same cycle as a pop → data retained, `overflow` stays 0, write order preserved.
- **Level hold:** `acc_done_wrap` held high 10 cycles → exactly one capture and one `out_we`.
- **Ignored inputs:** edges in IDLE/DONE produce no writes and no `overflow`. `start` during COLLECT leaves counters unchanged.

Source files
------------

// File: rtl/mha_out_collector_if.sv
// mha_out_collector_if
// Groups the handshake and data signals of the MHA output collector.
//   master : the environment around the collector (drives start, capture
//            inputs and write backpressure, observes write port and status)
//   slave  : the collector itself
// Signals:
//   start          one-cycle pulse arming collection of a new matrix
//   acc_done_wrap  level from the systolic wrapper, rising edge = new block
//   acc_data       accumulated result block, valid in the edge cycle
//   out_ready      output BRAM/consumer accepts a write this cycle
//   out_we         one-cycle write strobe per block
//   out_addr       row-major block address
//   out_data       block being written
//   busy           collector is collecting or draining
//   done           full matrix written
//   overflow       sticky: a capture was dropped on a full FIFO
interface mha_out_collector_if #(
  parameter int WIDTH_OUT  = 64,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  acc_done_wrap;
  logic [WIDTH_OUT-1:0]  acc_data;
  logic                  out_ready;
  logic                  out_we;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [WIDTH_OUT-1:0]  out_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, acc_done_wrap, acc_data, out_ready,
    input  out_we, out_addr, out_data, busy, done, overflow
  );

  modport slave (
    input  start, acc_done_wrap, acc_data, out_ready,
    output out_we, out_addr, out_data, busy, done, overflow
  );
endinterface

// File: rtl/mha_out_collector.sv
// mha_out_collector
// Captures accumulated result blocks from the systolic wrapper on each rising
// edge of acc_done_wrap, buffers them in a small FIFO and drains them into the
// output BRAM write port in row-major block order under backpressure. Reports
// completion once ROW_BLOCKS x COL_BLOCKS blocks have been written.
// Ports:
//   clk  single clock domain
//   rst  asynchronous, active-high reset
//   bus  slave side of mha_out_collector_if (capture inputs, write port,
//        busy/done/overflow status)
module mha_out_collector #(
  parameter int WIDTH_OUT  = 64,
  parameter int ROW_BLOCKS = 4,
  parameter int COL_BLOCKS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mha_out_collector_if.slave bus
);

  localparam int TOTAL = ROW_BLOCKS * COL_BLOCKS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int ROW_W = (ROW_BLOCKS > 1) ? $clog2(ROW_BLOCKS) : 1;
  localparam int COL_W = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROW_BLOCKS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COL_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  state_e                state_q;
  logic                  accDoneWrap_q;
  logic [CNT_W-1:0]      capCnt_q;
  logic [CNT_W-1:0]      wrCnt_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic [PTR_W:0]        wrPtr_q;
  logic [PTR_W:0]        rdPtr_q;
  logic [WIDTH_OUT-1:0]  mem_q [FIFO_DEPTH];
  logic                  outWe_q;
  logic [ADDR_WIDTH-1:0] outAddr_q;
  logic [WIDTH_OUT-1:0]  outData_q;
  logic                  overflow_q;

  logic                  accEdge;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  active;
  logic                  capture;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] blockAddr;

  // Decode edge, FIFO status and the per-cycle push/pop decisions. The pointers
  // carry one extra wrap bit so full and empty can be told apart. A capture on
  // a full FIFO is still accepted if a pop frees a slot in the same cycle.
  always_comb begin
    accEdge   = bus.acc_done_wrap & ~accDoneWrap_q;
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    active    = (state_q == COLLECT) || (state_q == DRAIN);
    capture   = (state_q == COLLECT) && accEdge;
    pop       = active && !fifoEmpty && bus.out_ready;
    push      = capture && (!fifoFull || pop);
    drop      = capture && fifoFull && !pop;
    blockAddr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(COL_BLOCKS) + ADDR_WIDTH'(col_q);
  end

  // FIFO storage. Contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[PTR_W-1:0]] <= bus.acc_data;
    end
  end

  // Control FSM with counters, FIFO pointers and registered write port.
  // A new start from IDLE/DONE flushes everything from the previous matrix.
  // Dropped captures still count towards the capture total but consume no
  // address, so a matrix with an overflow never reaches DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      accDoneWrap_q <= 1'b0;
      capCnt_q      <= '0;
      wrCnt_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      outWe_q       <= 1'b0;
      outAddr_q     <= '0;
      outData_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      accDoneWrap_q <= bus.acc_done_wrap;
      outWe_q       <= pop;

      if (push) begin
        wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
      end
      if (capture) begin
        capCnt_q <= capCnt_q + CNT_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end

      if (pop) begin
        rdPtr_q   <= rdPtr_q + (PTR_W+1)'(1);
        outAddr_q <= blockAddr;
        outData_q <= mem_q[rdPtr_q[PTR_W-1:0]];
        wrCnt_q   <= wrCnt_q + CNT_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q    <= COLLECT;
            capCnt_q   <= '0;
            wrCnt_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (capture && (capCnt_q == TOTAL_C - CNT_W'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((wrCnt_q == TOTAL_C) && fifoEmpty) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_we   = outWe_q;
  assign bus.out_addr = outAddr_q;
  assign bus.out_data = outData_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q == COLLECT) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_mha_out_collector.sv
// tb_mha_out_collector
// Directed bench for mha_out_collector with default parameters (4x4 blocks,
// 64-bit data, 4-entry FIFO). Expected writes are queued as stimulus is
// issued; a monitor pops and compares on every out_we pulse.
module tb_mha_out_collector;

  logic clk;
  logic rst;

  mha_out_collector_if #(.WIDTH_OUT(64), .ADDR_WIDTH(4)) busIf ();

  mha_out_collector #(
    .WIDTH_OUT (64),
    .ROW_BLOCKS(4),
    .COL_BLOCKS(4),
    .FIFO_DEPTH(4),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } expWrite_t;

  expWrite_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && busIf.out_we) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedWrite: got addr=%0d data=%h, none expected",
                 busIf.out_addr, busIf.out_data);
      end else begin
        expWrite_t e;
        e = expQ.pop_front();
        if (busIf.out_addr !== e.addr || busIf.out_data !== e.data) begin
          errors++;
          $display("[TB] FAIL writeMatch: got addr=%0d data=%h, expected addr=%0d data=%h",
                   busIf.out_addr, busIf.out_data, e.addr, e.data);
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the bench's expected value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Queue an expected write for the monitor.
  task automatic expectWrite(input logic [3:0] addr, input logic [63:0] data);
    expWrite_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Raise acc_done_wrap with data for 'hold' cycles, then drop it for one cycle.
  task automatic applyStimulus(input logic [63:0] data, input int hold);
    busIf.acc_done_wrap = 1'b1;
    busIf.acc_data      = data;
    repeat (hold) tick();
    busIf.acc_done_wrap = 1'b0;
    tick();
  endtask

  // One-cycle start pulse.
  task automatic pulseStart();
    busIf.start = 1'b1;
    tick();
    busIf.start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"},   64'(busIf.out_we),   64'h0);
    checkOutput({tag, "_addr"}, 64'(busIf.out_addr), 64'h0);
    checkOutput({tag, "_data"}, busIf.out_data,      64'h0);
    checkOutput({tag, "_busy"}, 64'(busIf.busy),     64'h0);
    checkOutput({tag, "_done"}, 64'(busIf.done),     64'h0);
    checkOutput({tag, "_ovf"},  64'(busIf.overflow), 64'h0);
  endtask

  initial begin
    rst                 = 1'b1;
    busIf.start         = 1'b0;
    busIf.acc_done_wrap = 1'b0;
    busIf.acc_data      = '0;
    busIf.out_ready     = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // Edge while IDLE: no capture, no overflow, no write.
    applyStimulus(64'hDEAD, 1);
    tick();
    checkOutput("idleEdgeOvf", 64'(busIf.overflow), 64'h0);
    checkOutput("idleEdgeBusy", 64'(busIf.busy), 64'h0);

    // Fill 14 blocks with writes, hold the last two in the FIFO, then reset
    // asynchronously while draining.
    busIf.out_ready = 1'b1;
    pulseStart();
    checkOutput("startBusy", 64'(busIf.busy), 64'h1);
    for (int i = 0; i < 14; i++) begin
      expectWrite(4'(i), 64'h1000 + 64'(i));
      applyStimulus(64'h1000 + 64'(i), 1);
    end
    busIf.out_ready = 1'b0;
    applyStimulus(64'h100E, 1);
    applyStimulus(64'h100F, 1);
    tick();
    checkOutput("drainBusy", 64'(busIf.busy), 64'h1);
    checkOutput("drainLastAddr", 64'(busIf.out_addr), 64'd13);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("asyncRst");
    tick();
    rst = 1'b0;
    busIf.out_ready = 1'b1;
    tick();

    // Full matrix after reset: level hold on block 5, stray start before block 8.
    pulseStart();
    checkOutput("start2Busy", 64'(busIf.busy), 64'h1);
    for (int i = 0; i < 16; i++) begin
      logic [63:0] d;
      d = 64'h0123_4567_89AB_0000 | 64'(i);
      expectWrite(4'(i), d);
      if (i == 8) pulseStart();
      applyStimulus(d, (i == 5) ? 10 : 1);
      if (i == 0) begin
        checkOutput("latencyWe", 64'(busIf.out_we), 64'h1);
        checkOutput("latencyAddr", 64'(busIf.out_addr), 64'h0);
      end
    end
    checkOutput("lastWriteWe", 64'(busIf.out_we), 64'h1);
    checkOutput("lastWriteAddr", 64'(busIf.out_addr), 64'd15);
    checkOutput("doneBeforeLast", 64'(busIf.done), 64'h0);
    tick();
    checkOutput("doneAfterLast", 64'(busIf.done), 64'h1);
    checkOutput("busyAfterLast", 64'(busIf.busy), 64'h0);
    repeat (3) tick();
    checkOutput("doneHeld", 64'(busIf.done), 64'h1);
    applyStimulus(64'hEEEE, 1);
    tick();
    checkOutput("doneEdgeOvf", 64'(busIf.overflow), 64'h0);
    checkOutput("doneEdgeDone", 64'(busIf.done), 64'h1);
    checkOutput("matrixSbEmpty", 64'(expQ.size()), 64'h0);

    // Full FIFO with a pop in the same cycle as a new capture.
    busIf.out_ready = 1'b0;
    pulseStart();
    checkOutput("restartBusy", 64'(busIf.busy), 64'h1);
    checkOutput("restartDone", 64'(busIf.done), 64'h0);
    for (int i = 0; i < 4; i++) begin
      expectWrite(4'(i), 64'hC0 + 64'(i));
      applyStimulus(64'hC0 + 64'(i), 1);
    end
    expectWrite(4'd4, 64'hC4);
    busIf.out_ready     = 1'b1;
    busIf.acc_done_wrap = 1'b1;
    busIf.acc_data      = 64'hC4;
    tick();
    busIf.acc_done_wrap = 1'b0;
    tick();
    checkOutput("simulPopOvf", 64'(busIf.overflow), 64'h0);
    repeat (6) tick();
    checkOutput("simulPopSbEmpty", 64'(expQ.size()), 64'h0);

    // Collection cannot be restarted mid-COLLECT, so reset before the next test.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Backpressure: four captures fill the FIFO, the fifth is dropped.
    busIf.out_ready = 1'b0;
    pulseStart();
    for (int i = 0; i < 4; i++) begin
      expectWrite(4'(i), 64'hB0 + 64'(i));
      applyStimulus(64'hB0 + 64'(i), 1);
    end
    checkOutput("fullNoOvf", 64'(busIf.overflow), 64'h0);
    busIf.acc_done_wrap = 1'b1;
    busIf.acc_data      = 64'hB4;
    tick();
    checkOutput("dropOvf", 64'(busIf.overflow), 64'h1);
    busIf.acc_done_wrap = 1'b0;
    tick();
    busIf.out_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bpWe%0d", k), 64'(busIf.out_we), 64'h1);
      checkOutput($sformatf("bpAddr%0d", k), 64'(busIf.out_addr), 64'(k));
      tick();
    end
    checkOutput("bpWeAfter", 64'(busIf.out_we), 64'h0);
    checkOutput("bpOvfSticky", 64'(busIf.overflow), 64'h1);
    checkOutput("bpSbEmpty", 64'(expQ.size()), 64'h0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
